cdb_arbiter: RTL and testbench

//   Producer side of the common data bus (CDB). Collects writeback packets from N_FU

---
 rtl/cdb_arbiter_if.sv | 40 ++++
 rtl/cdb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Writeback packet type and the arbiter's bundle: per-unit writeback inputs,
// per-unit ready, flush, and the two registered CDB lanes.
package cdb_pkg;
    localparam int TAG_W = 6;
    localparam int RES_W = 32;

    typedef struct packed {
        logic             is_valid;
        logic [TAG_W-1:0] dest_tag;
        logic [RES_W-1:0] result;
    } writeback_packet_t;
endpackage

interface cdb_arbiter_if #(
    parameter int N_FU = 4
);
    import cdb_pkg::*;

    logic                         flush;
    writeback_packet_t [N_FU-1:0] fu_wb;
    logic [N_FU-1:0]              fu_rdy;
    writeback_packet_t            cdb_port0;
    writeback_packet_t            cdb_port1;

    modport master (
        input  flush,
        input  fu_wb,
        output fu_rdy,
        output cdb_port0,
        output cdb_port1
    );

    modport slave (
        output flush,
        output fu_wb,
        input  fu_rdy,
        input  cdb_port0,
        input  cdb_port1
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-unit writeback buffering with a dual-lane round-robin CDB grant; 2-cycle
// min latency, units stall through fu_rdy when their buffer is full.

// Small FIFO: head is visible combinationally, push/pop land at posedge; caller
// never pushes when full nor pops when empty.
module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_FU       = 4,
    parameter int FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(N_FU);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int PKT_W = $bits(writeback_packet_t);

    logic [CW-1:0]     count [N_FU];
    writeback_packet_t head  [N_FU];
    logic [N_FU-1:0]   nonempty;
    logic [N_FU-1:0]   rdy;
    logic [N_FU-1:0]   push;
    logic [N_FU-1:0]   pop;

    logic              g0_vld, g1_vld;
    logic [PTR_W-1:0]  g0_idx, g1_idx;
    logic [PTR_W-1:0]  last_idx, rr_next;
    logic [PTR_W-1:0]  rr_ptr;
    writeback_packet_t lane0_pkt, lane1_pkt;
    writeback_packet_t cdb0_q, cdb1_q;

    for (genvar i = 0; i < N_FU; i++) begin : g_src
        cdb_fifo #(
            .WIDTH(PKT_W),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush   (bus.flush),
            .push    (push[i]),
            .push_dat(bus.fu_wb[i]),
            .pop     (pop[i]),
            .head_dat(head[i]),
            .count   (count[i])
        );
    end

    // Ready depends only on registered occupancy, never on this cycle's grant.
    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            nonempty[i] = (count[i] != '0);
            rdy[i]      = !rst && (count[i] < CW'(FIFO_DEPTH));
            push[i]     = !bus.flush && bus.fu_wb[i].is_valid && rdy[i];
        end
    end

    assign bus.fu_rdy = rdy;

    always_comb begin
        int s;
        s      = 0;
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        for (int k = 0; k < N_FU; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= N_FU) s = s - N_FU;
            if (nonempty[s]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = PTR_W'(s);
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = PTR_W'(s);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            pop[i] = !bus.flush &&
                     ((g0_vld && (g0_idx == PTR_W'(i))) ||
                      (g1_vld && (g1_idx == PTR_W'(i))));
        end
    end

    always_comb begin
        lane0_pkt          = head[g0_idx];
        lane0_pkt.is_valid = 1'b1;
        lane1_pkt          = head[g1_idx];
        lane1_pkt.is_valid = 1'b1;
        last_idx           = g1_vld ? g1_idx : g0_idx;
        rr_next            = (last_idx == PTR_W'(N_FU - 1)) ? '0 : last_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb0_q <= '0;
            cdb1_q <= '0;
            rr_ptr <= '0;
        end else if (bus.flush) begin
            cdb0_q <= '0;
            cdb1_q <= '0;
            rr_ptr <= '0;
        end else begin
            cdb0_q <= g0_vld ? lane0_pkt : '0;
            cdb1_q <= g1_vld ? lane1_pkt : '0;
            if (g0_vld) rr_ptr <= rr_next;
        end
    end

    assign bus.cdb_port0 = cdb0_q;
    assign bus.cdb_port1 = cdb1_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic checked against
// a queue-based model of buffering, round-robin dual grant and flush.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N_FU  = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    writeback_packet_t mq [N_FU][$];
    int                m_ptr  = 0;
    writeback_packet_t m_exp0 = '0;
    writeback_packet_t m_exp1 = '0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_FU(N_FU)) bus ();

    cdb_arbiter #(
        .N_FU      (N_FU),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    function automatic writeback_packet_t mk(input int tag, input logic [RES_W-1:0] res);
        writeback_packet_t p;
        p.is_valid = 1'b1;
        p.dest_tag = TAG_W'(tag);
        p.result   = res;
        return p;
    endfunction

    function automatic logic [N_FU-1:0] m_rdy();
        logic [N_FU-1:0] r;
        for (int i = 0; i < N_FU; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    task automatic clear_inputs();
        bus.flush = 1'b0;
        for (int i = 0; i < N_FU; i++) bus.fu_wb[i] = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_FU; i++) mq[i].delete();
        m_ptr  = 0;
        m_exp0 = '0;
        m_exp1 = '0;
    endtask

    // One clock: the model consumes the inputs currently driven, then time advances to the next negedge.
    task automatic tick();
        writeback_packet_t n0, n1, p;
        bit acc [N_FU];
        int found, last, s;
        n0 = '0; n1 = '0; found = 0; last = -1;
        for (int i = 0; i < N_FU; i++)
            acc[i] = bus.fu_wb[i].is_valid && (mq[i].size() < DEPTH);
        if (bus.flush) begin
            for (int i = 0; i < N_FU; i++) mq[i].delete();
            m_ptr = 0;
        end else begin
            for (int k = 0; k < N_FU; k++) begin
                s = (m_ptr + k) % N_FU;
                if (found < 2 && mq[s].size() > 0) begin
                    p = mq[s].pop_front();
                    if (found == 0) n0 = p; else n1 = p;
                    found++;
                    last = s;
                end
            end
            for (int i = 0; i < N_FU; i++) if (acc[i]) mq[i].push_back(bus.fu_wb[i]);
            if (last >= 0) m_ptr = (last + 1) % N_FU;
        end
        @(posedge clk);
        m_exp0 = n0;
        m_exp1 = n1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.cdb_port0.is_valid !== 1'b0) begin errors++; $display("FAIL reset_port0: got %b want 0", bus.cdb_port0.is_valid); end
        checks++; if (bus.cdb_port1.is_valid !== 1'b0) begin errors++; $display("FAIL reset_port1: got %b want 0", bus.cdb_port1.is_valid); end
        checks++; if (bus.fu_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy_held: got %b want 0000", bus.fu_rdy); end
        rst = 1'b0;
        model_clear();
        #1;
        checks++; if (bus.fu_rdy !== 4'b1111) begin errors++; $display("FAIL reset_rdy_release: got %b want 1111", bus.fu_rdy); end
        tick();
        checks++; if (bus.cdb_port0 !== '0 || bus.cdb_port1 !== '0) begin errors++; $display("FAIL reset_idle: got %h/%h want 0/0", bus.cdb_port0, bus.cdb_port1); end
    endtask

    task automatic test_single();
        do_reset();
        bus.fu_wb[0] = mk(5, 32'hDEAD_BEEF);
        tick();
        clear_inputs();
        checks++; if (bus.cdb_port0.is_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bus.cdb_port0.is_valid); end
        tick();
        checks++; if (bus.cdb_port0 !== mk(5, 32'hDEAD_BEEF)) begin errors++; $display("FAIL single_port0: got %h want %h", bus.cdb_port0, mk(5, 32'hDEAD_BEEF)); end
        checks++; if (bus.cdb_port1.is_valid !== 1'b0) begin errors++; $display("FAIL single_port1: got %b want 0", bus.cdb_port1.is_valid); end
        tick();
        checks++; if (bus.cdb_port0.is_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b want 0", bus.cdb_port0.is_valid); end
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < N_FU; i++) bus.fu_wb[i] = mk(i + 1, 32'h1000 + i);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.cdb_port0 !== mk(1, 32'h1000) || bus.cdb_port1 !== mk(2, 32'h1001)) begin errors++; $display("FAIL burst_c3: got %h/%h want tags 1/2", bus.cdb_port0, bus.cdb_port1); end
        tick();
        checks++; if (bus.cdb_port0 !== mk(3, 32'h1002) || bus.cdb_port1 !== mk(4, 32'h1003)) begin errors++; $display("FAIL burst_c4: got %h/%h want tags 3/4", bus.cdb_port0, bus.cdb_port1); end
        tick();
        checks++; if (bus.cdb_port0.is_valid !== 1'b0 || bus.cdb_port1.is_valid !== 1'b0) begin errors++; $display("FAIL burst_c5: got %b/%b want 0/0", bus.cdb_port0.is_valid, bus.cdb_port1.is_valid); end
    endtask

    task automatic test_push_pop();
        do_reset();
        bus.fu_wb[2] = mk(8, 32'h88);
        tick();
        bus.fu_wb[2] = mk(9, 32'h99);
        tick();
        clear_inputs();
        checks++; if (bus.cdb_port0 !== mk(8, 32'h88) || bus.cdb_port1.is_valid !== 1'b0) begin errors++; $display("FAIL pushpop_first: got %h/%h want tag 8/idle", bus.cdb_port0, bus.cdb_port1); end
        checks++; if (bus.fu_rdy[2] !== 1'b1) begin errors++; $display("FAIL pushpop_rdy: got %b want 1", bus.fu_rdy[2]); end
        tick();
        checks++; if (bus.cdb_port0 !== mk(9, 32'h99)) begin errors++; $display("FAIL pushpop_second: got %h want %h", bus.cdb_port0, mk(9, 32'h99)); end
        tick();
        checks++; if (bus.cdb_port0.is_valid !== 1'b0) begin errors++; $display("FAIL pushpop_drained: got %b want 0", bus.cdb_port0.is_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) bus.fu_wb[i] = mk(20 + i, 32'h2000 + i);
        tick();
        clear_inputs();
        bus.fu_wb[3] = mk(23, 32'h2003);
        bus.flush = 1'b1;
        tick();
        clear_inputs();
        checks++; if (bus.cdb_port0.is_valid !== 1'b0 || bus.cdb_port1.is_valid !== 1'b0) begin errors++; $display("FAIL flush_cdb: got %b/%b want 0/0", bus.cdb_port0.is_valid, bus.cdb_port1.is_valid); end
        checks++; if (bus.fu_rdy !== 4'b1111) begin errors++; $display("FAIL flush_rdy: got %b want 1111", bus.fu_rdy); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus.cdb_port0.is_valid !== 1'b0 || bus.cdb_port1.is_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got %h/%h want idle", bus.cdb_port0, bus.cdb_port1); end
        end
    endtask

    task automatic test_saturation();
        int seq [N_FU], exp_seq [N_FU], gap [N_FU];
        logic [RES_W-1:0] res [N_FU];
        bit acc [N_FU], granted [N_FU];
        bit saw_low, any;
        writeback_packet_t lanes [2];
        int t, src;
        do_reset();
        saw_low = 0;
        for (int i = 0; i < N_FU; i++) begin seq[i] = 0; exp_seq[i] = 0; gap[i] = 0; res[i] = $urandom; end
        for (int cyc = 0; cyc < 28; cyc++) begin
            for (int i = 0; i < N_FU; i++) begin
                bus.fu_wb[i] = (cyc < 20) ? mk(i * 16 + (seq[i] % 16), res[i]) : '0;
                acc[i] = bus.fu_wb[i].is_valid && (mq[i].size() < DEPTH);
            end
            tick();
            for (int i = 0; i < N_FU; i++) if (acc[i]) begin seq[i]++; res[i] = $urandom; end
            if (bus.fu_rdy !== 4'b1111) saw_low = 1;
            checks++; if (bus.cdb_port0 !== m_exp0 || bus.cdb_port1 !== m_exp1) begin errors++; $display("FAIL sat_lanes: got %h/%h want %h/%h", bus.cdb_port0, bus.cdb_port1, m_exp0, m_exp1); end
            lanes[0] = bus.cdb_port0;
            lanes[1] = bus.cdb_port1;
            any = 0;
            for (int i = 0; i < N_FU; i++) granted[i] = 0;
            for (int l = 0; l < 2; l++) begin
                if (lanes[l].is_valid === 1'b1) begin
                    any = 1;
                    t   = int'(lanes[l].dest_tag);
                    src = t / 16;
                    granted[src] = 1;
                    checks++; if (t % 16 != exp_seq[src] % 16) begin errors++; $display("FAIL sat_order: src %0d got seq %0d want %0d", src, t % 16, exp_seq[src] % 16); end
                    exp_seq[src]++;
                end
            end
            if (any && cyc < 20) begin
                for (int i = 0; i < N_FU; i++) begin
                    if (granted[i]) gap[i] = 0; else gap[i]++;
                    checks++; if (gap[i] >= 2) begin errors++; $display("FAIL sat_fair: src %0d got gap %0d want <2", i, gap[i]); end
                end
            end
        end
        for (int i = 0; i < N_FU; i++) begin
            checks++; if (exp_seq[i] != seq[i]) begin errors++; $display("FAIL sat_count: src %0d got %0d emitted want %0d", i, exp_seq[i], seq[i]); end
        end
        checks++; if (!saw_low) begin errors++; $display("FAIL sat_backpressure: got rdy never low want some low"); end
    endtask

    task automatic test_random();
        writeback_packet_t pend [N_FU];
        bit has [N_FU], acc [N_FU];
        bit fl;
        do_reset();
        for (int i = 0; i < N_FU; i++) has[i] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            bus.flush = ($urandom_range(0, 24) == 0);
            fl = bus.flush;
            for (int i = 0; i < N_FU; i++) begin
                if (!has[i] && $urandom_range(0, 99) < 60) begin
                    pend[i] = mk(int'($urandom_range(0, 63)), $urandom);
                    has[i]  = 1;
                end
                bus.fu_wb[i] = has[i] ? pend[i] : '0;
                acc[i] = has[i] && (mq[i].size() < DEPTH);
            end
            tick();
            for (int i = 0; i < N_FU; i++) if (acc[i] || fl) has[i] = 0;
            checks++; if (bus.cdb_port0 !== m_exp0) begin errors++; $display("FAIL rand_port0 c%0d: got %h want %h", cyc, bus.cdb_port0, m_exp0); end
            checks++; if (bus.cdb_port1 !== m_exp1) begin errors++; $display("FAIL rand_port1 c%0d: got %h want %h", cyc, bus.cdb_port1, m_exp1); end
            checks++; if (bus.fu_rdy !== m_rdy()) begin errors++; $display("FAIL rand_rdy c%0d: got %b want %b", cyc, bus.fu_rdy, m_rdy()); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < N_FU; i++) bus.fu_wb[i] = mk(40 + i, 32'h4000 + i);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.cdb_port0.is_valid !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", bus.cdb_port0.is_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.cdb_port0 !== '0 || bus.cdb_port1 !== '0) begin errors++; $display("FAIL midrst_clear: got %h/%h want 0/0", bus.cdb_port0, bus.cdb_port1); end
        checks++; if (bus.fu_rdy !== 4'b0000) begin errors++; $display("FAIL midrst_rdy: got %b want 0000", bus.fu_rdy); end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.fu_rdy !== 4'b1111) begin errors++; $display("FAIL midrst_release: got %b want 1111", bus.fu_rdy); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (bus.cdb_port0.is_valid !== 1'b0 || bus.cdb_port1.is_valid !== 1'b0) begin errors++; $display("FAIL midrst_lost: got %h/%h want idle", bus.cdb_port0, bus.cdb_port1); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_push_pop();
        test_flush();
        test_saturation();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
